// File: rtl/n_out_port_alloc_ctrl.sv
// North output port allocator: packet-level round-robin over s/w/e/l inputs,
// crossbar lock from head to tail, and downstream credit flow control.
module n_out_port_alloc_ctrl #(
  parameter int CREDIT_MAX = 4,
  parameter int CREDIT_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req_i,
  input  logic [3:0]          flit_valid_i,
  input  logic [3:0]          tail_i,
  input  logic                credit_return_i,
  output logic [3:0]          grant_o,
  output logic [2:0]          xbar_sel_o,
  output logic [3:0]          flit_pop_o,
  output logic                out_valid_o,
  output logic [CREDIT_W-1:0] credit_cnt_o,
  output logic [1:0]          rr_ptr_o,
  output logic                change_order_o,
  output logic                busy_o
);

  localparam logic [CREDIT_W-1:0] CREDIT_RST = CREDIT_W'(CREDIT_MAX);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [2:0]          sel_q, sel_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic                chg_q, chg_d;
  logic                xfer;
  logic                xfer_tail;
  logic [1:0]          win_idx;
  logic [1:0]          g_idx;

  // Pointer index i (0=s..3=l) corresponds to request bit 3-i.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[2'd3 - idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [CREDIT_W-1:0] credit_next(input logic [CREDIT_W-1:0] cnt,
                                                      input logic dec, input logic inc);
    credit_next = cnt;
    if (dec && !inc)
      credit_next = cnt - 1'b1;
    else if (inc && !dec && cnt != CREDIT_RST)
      credit_next = cnt + 1'b1;
  endfunction

  always_comb begin
    g_idx = 2'd0;
    unique case (grant_q)
      4'b1000: g_idx = 2'd0;
      4'b0100: g_idx = 2'd1;
      4'b0010: g_idx = 2'd2;
      4'b0001: g_idx = 2'd3;
      default: g_idx = 2'd0;
    endcase
  end

  // grant_q is zero outside LOCKED, so masking by it also gates on state.
  assign xfer      = (state_q == LOCKED) && |(grant_q & flit_valid_i) && (credit_q != '0);
  assign xfer_tail = xfer && |(grant_q & tail_i);
  assign win_idx   = rr_pick(req_i, rr_ptr_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    chg_d    = 1'b0;
    credit_d = credit_next(credit_q, xfer, credit_return_i);
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = LOCKED;
          grant_d = 4'b1000 >> win_idx;
          sel_d   = 3'(win_idx) + 3'd1;
        end
      end
      LOCKED: begin
        if (xfer_tail) begin
          state_d  = IDLE;
          grant_d  = 4'b0000;
          sel_d    = 3'd0;
          rr_ptr_d = g_idx + 2'd1;
          chg_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 4'b0000;
      sel_q    <= 3'd0;
      credit_q <= CREDIT_RST;
      rr_ptr_q <= 2'd0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      credit_q <= credit_d;
      rr_ptr_q <= rr_ptr_d;
      chg_q    <= chg_d;
    end
  end

  assign grant_o        = grant_q;
  assign xbar_sel_o     = sel_q;
  assign flit_pop_o     = xfer ? grant_q : 4'b0000;
  assign out_valid_o    = xfer;
  assign credit_cnt_o   = credit_q;
  assign rr_ptr_o       = rr_ptr_q;
  assign change_order_o = chg_q;
  assign busy_o         = (state_q == LOCKED);

endmodule

// File: doc/n_out_port_alloc_ctrl.md
# n_out_port_alloc_ctrl

Packet-level round-robin allocator and flow controller for one router output port (north). It shares the output among the south, west, east and local input buffers. It locks the crossbar to one input for a whole packet, from head flit to tail flit, and gates each flit transfer on downstream credits. It drives the 5-to-1 output mux select and pulses the round-robin order-change strobe when a packet completes.

## Interface
Parameters:
- CREDIT_MAX, 4, number of downstream buffer slots; also the reset value of the credit count.
- CREDIT_W, 3, width of the credit counter; must satisfy 2^CREDIT_W > CREDIT_MAX.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- req_i  input  4  per-input request for this output; [3]=s, [2]=w, [1]=e, [0]=l.
- flit_valid_i  input  4  the selected input buffer has a flit at its head; same bit order.
- tail_i  input  4  the head flit of that input is a tail flit; same bit order.
- credit_return_i  input  1  one-cycle pulse: the downstream router freed one slot.
- grant_o  output  4  one-hot registered grant, held for the whole packet.
- xbar_sel_o  output  3  mux select: 0=none, 1=s, 2=w, 3=e, 4=l.
- flit_pop_o  output  4  one-hot: the granted input's head flit is transferred this cycle.
- out_valid_o  output  1  a flit is presented on the north output this cycle.
- credit_cnt_o  output  CREDIT_W  current available downstream credits.
- rr_ptr_o  output  2  round-robin pointer: 0=s, 1=w, 2=e, 3=l.
- change_order_o  output  1  one-cycle pulse when a packet completes.
- busy_o  output  1  high while in state LOCKED.

## Operation
- There are two states: IDLE and LOCKED. busy_o = (state == LOCKED).
- IDLE arbitration:
  - The winner is the first set req_i bit found scanning s, w, e, l, starting at rr_ptr_o and wrapping.
  - If any request is present, register grant_o to the winner, set xbar_sel_o, and go to LOCKED.
  - If no request is present, stay in IDLE.
- LOCKED transfer:
  - xfer = flit_valid_i[g] && credit_cnt_o != 0, where g is the granted input.
  - When xfer is high: flit_pop_o[g]=1 and out_valid_o=1. Both are combinational in the same cycle.
  - req_i is ignored while LOCKED. The lock releases only on a transferred tail flit.
- Packet completion: xfer && tail_i[g] in cycle k. In cycle k+1:
  - state = IDLE.
  - grant_o = 0 and xbar_sel_o = 0.
  - rr_ptr_o = (g + 1) mod 4.
  - change_order_o = 1 for exactly one cycle.
- Single-flit packet: the head flit is also the tail. The grant then lasts exactly one cycle if a credit is available.
- Credit arithmetic, next-cycle value:
  - Decrement on xfer.
  - Increment on credit_return_i.
  - Both in the same cycle: unchanged.
  - credit_return_i while the count is at CREDIT_MAX with no xfer: count saturates at CREDIT_MAX.
  - No transfer ever occurs at 0 credits, so the count never underflows.
- flit_valid_i and tail_i bits of non-granted inputs have no effect.

## Timing
- Reset values:
  - grant_o = 0, xbar_sel_o = 0, flit_pop_o = 0, out_valid_o = 0.
  - credit_cnt_o = CREDIT_MAX, rr_ptr_o = 0, change_order_o = 0, busy_o = 0, state = IDLE.
- Reset asserted mid-packet drops the lock immediately and restores credits to CREDIT_MAX. No completion pulse is generated.
- Arbitration latency: req_i sampled in IDLE at cycle 0 → grant_o valid in cycle 1.
- First transfer: the earliest first-flit transfer is cycle 1.
- Throughput: one flit per cycle while credits last.
- Back-to-back packets: a tail in cycle k → IDLE in k+1 and a new grant in k+2. This is a one-cycle bubble per packet.
- A credit returned in cycle k is usable for a transfer in cycle k+1.

## Test plan
- Reset, then a 3-flit packet from l only (req_i=4'b0001) with credits=4 → grant_o=0001 in cycle 1 and pops in cycles 1-3. After that: credit_cnt_o=1, change_order_o pulses in cycle 4, rr_ptr_o=0 (wraps from l to s).
- All four inputs request continuously, each sending single-flit packets, with credit_return_i pulsed every cycle → grants in order s, w, e, l, s with one idle cycle between grants, and rr_ptr_o cycling 1, 2, 3, 0.
- Credit starvation: a 6-flit packet from w with no credit returns → 4 pops, then out_valid_o=0 and grant held. Pulse credit_return_i twice → 2 more pops. The lock releases after the tail.
- Credit_return_i and xfer in the same cycle with credit_cnt_o=2 → credit_cnt_o stays 2. credit_return_i pulsed at count 4 with no xfer → stays 4.
- Mid-packet, the granted e input drops req_i while s raises its request → grant_o stays 0010 until e's tail transfers. s is granted two cycles after the tail.
- Assert reset during flit 2 of a packet → all outputs return to reset values and credit_cnt_o=4. No change_order_o pulse occurs.
